butterfly_twiddle_stage: RTL and testbench

//  Pipelined fixed-point complex twiddle multiplier that sits directly upstream of the

---
 rtl/butterfly_twiddle_stage.sv | 112 +++++++++++
 tb/tb_butterfly_twiddle_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/butterfly_twiddle_stage.sv
// rtl/butterfly_twiddle_stage.sv - two-stage elastic complex twiddle multiplier feeding the FFT butterfly
module butterfly_twiddle_stage #(
    parameter int BIT_WIDTH  = 32,
    parameter int DECIMAL_PT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    input  logic [BIT_WIDTH-1:0] aR,
    input  logic [BIT_WIDTH-1:0] aC,
    input  logic [BIT_WIDTH-1:0] bR,
    input  logic [BIT_WIDTH-1:0] bC,
    input  logic [BIT_WIDTH-1:0] wR,
    input  logic [BIT_WIDTH-1:0] wC,
    output logic                 send_val,
    input  logic                 send_rdy,
    output logic [BIT_WIDTH-1:0] oaR,
    output logic [BIT_WIDTH-1:0] oaC,
    output logic [BIT_WIDTH-1:0] obR,
    output logic [BIT_WIDTH-1:0] obC
);

    localparam int W  = BIT_WIDTH;
    localparam int PW = 2 * BIT_WIDTH;

    logic          s1_val_q;
    logic [W-1:0]  s1_ar_q, s1_ac_q;
    logic [PW-1:0] p_rr_q, p_cc_q, p_rc_q, p_cr_q;

    logic          s2_val_q;
    logic [W-1:0]  s2_ar_q, s2_ac_q, s2_br_q, s2_bc_q;

    logic          s1_load, s2_load, accept;

    logic [PW-1:0] p_rr_d, p_cc_d, p_rc_d, p_cr_d;
    logic [PW:0]   diff_r, sum_c;
    logic [W-1:0]  s2_br_d, s2_bc_d;
    logic          unused_bits;

    assign s2_load  = s1_val_q && (!s2_val_q || send_rdy);
    assign s1_load  = !s1_val_q || s2_load;
    assign recv_rdy = s1_load && !reset;
    assign accept   = recv_val && recv_rdy;

    // Operands are sign-extended to the full product width so the multiply is exact.
    always_comb begin
        p_rr_d = $signed({{W{bR[W-1]}}, bR}) * $signed({{W{wR[W-1]}}, wR});
        p_cc_d = $signed({{W{bC[W-1]}}, bC}) * $signed({{W{wC[W-1]}}, wC});
        p_rc_d = $signed({{W{bR[W-1]}}, bR}) * $signed({{W{wC[W-1]}}, wC});
        p_cr_d = $signed({{W{bC[W-1]}}, bC}) * $signed({{W{wR[W-1]}}, wR});
    end

    // One extra bit keeps the sum/difference exact; taking bits [DP +: W] is the
    // arithmetic shift followed by wrap-around truncation.
    always_comb begin
        diff_r  = {p_rr_q[PW-1], p_rr_q} - {p_cc_q[PW-1], p_cc_q};
        sum_c   = {p_rc_q[PW-1], p_rc_q} + {p_cr_q[PW-1], p_cr_q};
        s2_br_d = diff_r[DECIMAL_PT +: W];
        s2_bc_d = sum_c[DECIMAL_PT +: W];
    end

    assign unused_bits = ^{diff_r[DECIMAL_PT-1:0], diff_r[PW:DECIMAL_PT+W],
                           sum_c[DECIMAL_PT-1:0],  sum_c[PW:DECIMAL_PT+W]};

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_val_q <= 1'b0;
            s1_ar_q  <= '0;
            s1_ac_q  <= '0;
            p_rr_q   <= '0;
            p_cc_q   <= '0;
            p_rc_q   <= '0;
            p_cr_q   <= '0;
        end else if (accept) begin
            s1_val_q <= 1'b1;
            s1_ar_q  <= aR;
            s1_ac_q  <= aC;
            p_rr_q   <= p_rr_d;
            p_cc_q   <= p_cc_d;
            p_rc_q   <= p_rc_d;
            p_cr_q   <= p_cr_d;
        end else if (s1_load) begin
            s1_val_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_val_q <= 1'b0;
            s2_ar_q  <= '0;
            s2_ac_q  <= '0;
            s2_br_q  <= '0;
            s2_bc_q  <= '0;
        end else if (s2_load) begin
            s2_val_q <= 1'b1;
            s2_ar_q  <= s1_ar_q;
            s2_ac_q  <= s1_ac_q;
            s2_br_q  <= s2_br_d;
            s2_bc_q  <= s2_bc_d;
        end else if (s2_val_q && send_rdy) begin
            s2_val_q <= 1'b0;
        end
    end

    assign send_val = s2_val_q;
    assign oaR      = s2_ar_q;
    assign oaC      = s2_ac_q;
    assign obR      = s2_br_q;
    assign obC      = s2_bc_q;

endmodule

// File: tb/tb_butterfly_twiddle_stage.sv
// tb/tb_butterfly_twiddle_stage.sv - scoreboard bench for butterfly_twiddle_stage
module tb_butterfly_twiddle_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        recv_val, recv_rdy, send_val, send_rdy;
    logic [31:0] aR, aC, bR, bC, wR, wC, oaR, oaC, obR, obC;

    always #5 clk = ~clk;

    butterfly_twiddle_stage #(.BIT_WIDTH(32), .DECIMAL_PT(16)) dut (
        .clk(clk), .reset(reset),
        .recv_val(recv_val), .recv_rdy(recv_rdy),
        .aR(aR), .aC(aC), .bR(bR), .bC(bC), .wR(wR), .wC(wC),
        .send_val(send_val), .send_rdy(send_rdy),
        .oaR(oaR), .oaC(oaC), .obR(obR), .obC(obC)
    );

    typedef struct {
        logic [31:0] ar, ac, br, bc, wr, wc, er, ec;
    } vec_t;

    typedef struct {
        logic [31:0] ar, ac, br, bc;
    } exp_t;

    vec_t vecs[16];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cmul(input logic [31:0] x1, input logic [31:0] y1,
                                         input logic [31:0] x2, input logic [31:0] y2,
                                         input bit is_sub);
        logic signed [64:0] a1, b1, a2, b2, r;
        a1 = {{33{x1[31]}}, x1};
        b1 = {{33{y1[31]}}, y1};
        a2 = {{33{x2[31]}}, x2};
        b2 = {{33{y2[31]}}, y2};
        r  = is_sub ? (a1 * b1 - a2 * b2) : (a1 * b1 + a2 * b2);
        r  = r >>> 16;
        return r[31:0];
    endfunction

    // One clock: drive at negedge, observe #1 later; the transfers happen at the next posedge.
    task automatic cycle(input logic rv, input logic sr, input vec_t v,
                         output logic accepted, output logic emitted);
        exp_t e;
        @(negedge clk);
        recv_val = rv;
        send_rdy = sr;
        aR = v.ar; aC = v.ac; bR = v.br; bC = v.bc; wR = v.wr; wC = v.wc;
        #1;
        emitted = send_val && send_rdy;
        if (emitted) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got obR=0x%08h, expected no beat", obR);
            end else begin
                e = sb.pop_front();
                if ({oaR, oaC, obR, obC} !== {e.ar, e.ac, e.br, e.bc}) begin
                    n_fail++;
                    $display("FAIL beat: got oa=(%08h,%08h) ob=(%08h,%08h), expected oa=(%08h,%08h) ob=(%08h,%08h)",
                             oaR, oaC, obR, obC, e.ar, e.ac, e.br, e.bc);
                end
            end
        end
        accepted = rv && recv_rdy;
        if (accepted) sb.push_back('{v.ar, v.ac, v.er, v.ec});
    endtask

    task automatic drain(input string name);
        logic acc, em;
        for (int i = 0; i < 40 && sb.size() > 0; i++) cycle(1'b0, 1'b1, vecs[0], acc, em);
        check(name, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc, em;
        int   n_acc, n_em;

        vecs[0] = '{32'h1234, 32'h5678, 32'h00020000, 0, 0, 32'h00010000, 0, 32'h00020000};
        vecs[1] = '{32'h1, 32'h2, 32'hFFFE8000, 0, 32'h8000, 0, 32'hFFFF4000, 0};
        vecs[2] = '{32'h3, 32'h4, 32'h1, 0, 32'h8000, 0, 0, 0};
        vecs[3] = '{32'h5, 32'h6, 32'hFFFFFFFF, 0, 32'h8000, 0, 32'hFFFFFFFF, 0};
        vecs[4] = '{32'h7, 32'h8, 32'h7FFF0000, 0, 32'h00020000, 0, 32'hFFFE0000, 0};
        vecs[5] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00010000, 32'h00020000,
                    32'h00030000, 32'h00040000, 32'hFFFB0000, 32'h000A0000};
        vecs[6] = '{32'hDEADBEEF, 32'hCAFEF00D, 32'hFFFF0000, 32'hFFFE0000,
                    32'h00008000, 32'hFFFF8000, 32'hFFFE8000, 32'hFFFF8000};
        vecs[7] = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h80000000,
                    32'h80000000, 32'h80000000, 0, 0};
        for (int i = 8; i < 16; i++) begin
            vecs[i].ar = $urandom; vecs[i].ac = $urandom;
            vecs[i].br = $urandom; vecs[i].bc = $urandom;
            vecs[i].wr = $urandom; vecs[i].wc = $urandom;
            vecs[i].er = cmul(vecs[i].br, vecs[i].wr, vecs[i].bc, vecs[i].wc, 1'b1);
            vecs[i].ec = cmul(vecs[i].br, vecs[i].wc, vecs[i].bc, vecs[i].wr, 1'b0);
        end

        reset = 1'b1; recv_val = 1'b0; send_rdy = 1'b1;
        aR = 0; aC = 0; bR = 0; bC = 0; wR = 0; wC = 0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_recv_rdy", recv_rdy, 0);
        check("reset_send_val", send_val, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset_recv_rdy", recv_rdy, 1);
        check("post_reset_send_val", send_val, 0);
        check("post_reset_obR", obR, 0);
        check("post_reset_oaR", oaR, 0);

        // Latency of a single rotate beat
        cycle(1'b1, 1'b1, vecs[0], acc, em);
        check("lat_accept", acc, 1);
        cycle(1'b0, 1'b1, vecs[0], acc, em);
        check("lat_not_early", send_val, 0);
        cycle(1'b0, 1'b1, vecs[0], acc, em);
        check("lat_valid", send_val, 1);
        drain("lat_drain");

        // Back-to-back stream of every table vector
        n_em = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b1, vecs[i], acc, em);
            check("stream_recv_rdy", acc, 1);
            n_em += int'(em);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, vecs[0], acc, em);
            n_em += int'(em);
        end
        check("stream_consecutive", n_em, 16);
        check("stream_empty", sb.size(), 0);

        // Backpressure: exactly two beats fit, then outputs hold on the first beat
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, vecs[8 + i], acc, em);
            n_acc += int'(acc);
            if (i >= 2) begin
                check("bp_recv_rdy_low", recv_rdy, 0);
                check("bp_send_val", send_val, 1);
                check("bp_hold_obR", obR, vecs[8].er);
                check("bp_hold_oaC", oaC, vecs[8].ac);
            end
        end
        check("bp_accepted", n_acc, 2);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, vecs[i + 1], acc, em);
        drain("bp_drain");

        // Reset while two beats are stalled
        cycle(1'b1, 1'b0, vecs[5], acc, em);
        cycle(1'b1, 1'b0, vecs[6], acc, em);
        @(negedge clk);
        reset = 1'b1; recv_val = 1'b1;
        #1;
        check("rst_mid_recv_rdy", recv_rdy, 0);
        @(negedge clk);
        reset = 1'b0; recv_val = 1'b0; send_rdy = 1'b1;
        #1;
        check("rst_mid_send_val", send_val, 0);
        check("rst_mid_recv_rdy_up", recv_rdy, 1);
        check("rst_mid_obC", obC, 0);
        sb.delete();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, vecs[0], acc, em);
        cycle(1'b1, 1'b1, vecs[5], acc, em);
        check("rst_after_accept", acc, 1);
        drain("rst_after_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
